fetch_frame_ctrl: RTL and testbench
===================================

Name: fetch_frame_ctrl

Overview:
- Per-frame sequencer for the fetch/remap datapath. The datapath comprises the line buffer, the LUT-driven read pointer and the bilinear-neighbour output stream.
- On each frame sync the block resets the datapath, kicks the LUT DMA and opens the video stream gate.
- It monitors the datapath output handshake, counts pixels and detects the end of frame.
- It flags length, overrun and stall errors, and reports frame completion to the host side.

Parameters:
- IMG_WIDTH, 640, output pixels per line
- IMG_HEIGHT, 480, output lines per frame
- RST_CYCLES, 4, length of the datapath reset pulse in clocks (≥1)
- TIMEOUT, 1048576, maximum idle cycles between accepted output beats in RUN before abort

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- Fsync  in  1  frame sync; a single-cycle pulse starts a frame
- enable  in  1  software enable; sampled only in IDLE
- err_clr  in  1  single-cycle pulse that clears all sticky error flags
- out_valid  in  1  datapath output valid (monitor only)
- out_ready  in  1  downstream ready on the datapath output (monitor only)
- out_last  in  1  datapath output last flag
- fetch_rst  out  1  synchronous reset to the datapath
- lut_start  out  1  single-cycle start pulse to the LUT DMA
- vid_gate  out  1  high while the video stream may be forwarded into the datapath
- busy  out  1  high in every state except IDLE
- frame_done  out  1  single-cycle pulse at the end of a frame
- err_len  out  1  sticky: frame length mismatch
- err_ovr  out  1  sticky: Fsync received while busy
- err_tmo  out  1  sticky: output stall timeout
- frame_cnt  out  16  number of completed frames (wraps)
- pix_cnt  out  20  accepted output beats in the current or last frame

Behaviour:
- Reset values:
  - state = IDLE.
  - fetch_rst = 1 while rst is asserted and in IDLE.
  - All other outputs 0; all counters 0.
- Accepted beat: out_valid && out_ready on the same clock.
- FRAME_PIX = IMG_WIDTH*IMG_HEIGHT.
- IDLE:
  - fetch_rst=1, vid_gate=0.
  - Fsync && enable → RESET. On that transition: load the reset counter with RST_CYCLES-1 and clear pix_cnt.
  - Fsync while !enable is ignored.
- RESET:
  - fetch_rst=1.
  - Decrement the reset counter; at 0 → ARM. The pulse therefore lasts exactly RST_CYCLES clocks.
- ARM:
  - One cycle; fetch_rst=0, lut_start=1 → RUN.
- RUN:
  - vid_gate=1.
  - Every accepted beat increments pix_cnt (saturates at 2^20-1) and clears the watchdog.
  - Otherwise the watchdog increments.
  - Accepted beat with out_last → DONE. Set err_len if the post-increment pix_cnt ≠ FRAME_PIX.
  - Accepted beat without out_last where the post-increment pix_cnt = FRAME_PIX+1 → set err_len, go to DONE.
  - Watchdog reaches TIMEOUT → set err_tmo, go to IDLE directly. No frame_done pulse; frame_cnt unchanged.
- DONE:
  - One cycle; vid_gate=0.
  - frame_done=1, frame_cnt+1 → IDLE.
- Fsync arriving in any state other than IDLE:
  - Set err_ovr.
  - Otherwise ignored; no restart.
- Fsync arriving in the same cycle that DONE returns to IDLE:
  - Ignored; not flagged as overrun.
- err_clr and an error event in the same cycle: the error event wins (flag remains 1).
- Flags are cleared only by err_clr or rst.
- Async rst mid-frame: all state returns to IDLE immediately. fetch_rst asserts asynchronously.
- lut_start is asserted exactly once per started frame.

Optional Feature:
- FETCH_CYCLE_STAT_EN
- Defined:
  - Adds output frame_cycles [31:0].
  - It latches the clock count from entering ARM to entering DONE, inclusive of ARM, exclusive of DONE.
  - Updated only on successful DONE; reset value 0.
- Undefined:
  - The port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=2, RST_CYCLES=4, enable=1. Fsync pulse at t0, then 8 accepted beats with out_last on the 8th →
   - fetch_rst low exactly 5 cycles after Fsync.
   - lut_start a single pulse.
   - frame_done one pulse one cycle after the 8th beat.
   - frame_cnt=1, pix_cnt=8, no errors.
2. Same configuration with out_last on beat 6 → frame_done pulses, err_len=1, pix_cnt=6.
3. Same configuration with no out_last; 9 beats → err_len set on beat 9, frame_done pulses, pix_cnt=9.
4. TIMEOUT=16; stall after 3 beats → err_tmo=1 on cycle 16 of the stall, return to IDLE, no frame_done, frame_cnt unchanged.
5. Fsync pulsed while in RUN → err_ovr=1 and the frame completes normally. Then err_clr → err_ovr=0. Fsync with enable=0 → stays IDLE, busy=0.
6. Assert rst for 1 cycle mid-RUN → outputs return to reset values immediately. A following Fsync starts a clean frame with pix_cnt counting from 0.

Source files
------------

// File: rtl/fetch_frame_ctrl.sv
// fetch_frame_ctrl: per-frame sequencer for the fetch/remap datapath (reset, LUT kick, gate, monitor).
// Define FETCH_CYCLE_STAT_EN to add the frame_cycles output (clocks spent in ARM+RUN of the last frame).
module fetch_frame_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Fsync,
    input  logic        enable,
    input  logic        err_clr,
    input  logic        out_valid,
    input  logic        out_ready,
    input  logic        out_last,
    output logic        fetch_rst,
    output logic        lut_start,
    output logic        vid_gate,
    output logic        busy,
    output logic        frame_done,
    output logic        err_len,
    output logic        err_ovr,
    output logic        err_tmo,
    output logic [15:0] frame_cnt,
`ifdef FETCH_CYCLE_STAT_EN
    output logic [31:0] frame_cycles,
`endif
    output logic [19:0] pix_cnt
);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [19:0] FRAME_PIX  = 20'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [19:0] FRAME_OVER = FRAME_PIX + 20'd1;

    typedef enum logic [2:0] {IDLE, RESET, ARM, RUN, DONE} state_t;

    state_t state, next;
    logic [RW-1:0] rst_cnt;
    logic [WW-1:0] wdog, wdog_next;
    logic [19:0] pix_next;
    logic beat, len_evt, tmo_evt, ovr_evt;

    assign beat      = out_valid && out_ready;
    assign pix_next  = (pix_cnt == '1) ? pix_cnt : pix_cnt + 20'd1;
    assign wdog_next = wdog + WW'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;

    always_comb begin
        next    = state;
        len_evt = 1'b0;
        tmo_evt = 1'b0;
        case (state)
            IDLE:    next = (Fsync && enable) ? RESET : IDLE;
            RESET:   next = (rst_cnt == '0) ? ARM : RESET;
            ARM:     next = RUN;
            RUN: begin
                if (beat && out_last) begin
                    next    = DONE;
                    len_evt = pix_next != FRAME_PIX;
                end else if (beat && pix_next == FRAME_OVER) begin
                    next    = DONE;
                    len_evt = 1'b1;
                end else if (!beat && wdog_next == WW'(TIMEOUT)) begin
                    next    = IDLE;
                    tmo_evt = 1'b1;
                end
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
        // A sync landing on the DONE->IDLE cycle is deliberately not an overrun.
        ovr_evt    = Fsync && (state == RESET || state == ARM || state == RUN);
        fetch_rst  = state == IDLE || state == RESET;
        lut_start  = state == ARM;
        vid_gate   = state == RUN;
        busy       = state != IDLE;
        frame_done = state == DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rst_cnt   <= '0;
            wdog      <= '0;
            pix_cnt   <= '0;
            frame_cnt <= '0;
            err_len   <= 1'b0;
            err_ovr   <= 1'b0;
            err_tmo   <= 1'b0;
        end else begin
            if (state == IDLE && next == RESET) begin
                rst_cnt <= RW'(RST_CYCLES - 1);
                pix_cnt <= '0;
            end else if (state == RESET) begin
                rst_cnt <= rst_cnt - RW'(1);
            end else if (state == RUN && beat) begin
                pix_cnt <= pix_next;
            end
            wdog <= (state == RUN && !beat) ? wdog_next : '0;
            if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
            // Set beats clear when both land together.
            err_len <= (err_len && !err_clr) || len_evt;
            err_ovr <= (err_ovr && !err_clr) || ovr_evt;
            err_tmo <= (err_tmo && !err_clr) || tmo_evt;
        end

`ifdef FETCH_CYCLE_STAT_EN
    logic [31:0] cyc;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cyc          <= '0;
            frame_cycles <= '0;
        end else begin
            cyc <= (state == ARM || state == RUN) ? cyc + 32'd1 : '0;
            if (state == RUN && next == DONE) frame_cycles <= cyc + 32'd1;
        end
`endif
endmodule

// File: tb/tb_fetch_frame_ctrl.sv
// tb_fetch_frame_ctrl: directed bench with a frame scoreboard for fetch_frame_ctrl (4x2 image, TIMEOUT=16).
module tb_fetch_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Fsync = 1'b0, enable = 1'b0, err_clr = 1'b0;
    logic out_valid = 1'b0, out_ready = 1'b0, out_last = 1'b0;
    logic fetch_rst, lut_start, vid_gate, busy, frame_done, err_len, err_ovr, err_tmo;
    logic [15:0] frame_cnt;
    logic [19:0] pix_cnt;
`ifdef FETCH_CYCLE_STAT_EN
    logic [31:0] frame_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int lut_pulses = 0;
    int done_pulses = 0;

    typedef struct {
        logic [15:0] fc;
        logic [19:0] pix;
        logic        len;
        logic        ovr;
    } exp_t;
    exp_t sb[$];

    fetch_frame_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .RST_CYCLES(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .Fsync(Fsync), .enable(enable), .err_clr(err_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .fetch_rst(fetch_rst), .lut_start(lut_start), .vid_gate(vid_gate), .busy(busy),
        .frame_done(frame_done), .err_len(err_len), .err_ovr(err_ovr), .err_tmo(err_tmo),
        .frame_cnt(frame_cnt),
`ifdef FETCH_CYCLE_STAT_EN
        .frame_cycles(frame_cycles),
`endif
        .pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst) begin
            if (lut_start === 1'b1) lut_pulses++;
            if (frame_done === 1'b1) done_pulses++;
        end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        int n = 0;
        int rst_low = 0;
        int lut_at = 0;
        Fsync = 1'b1;
        do begin
            step();
            n++;
            Fsync = 1'b0;
            if (fetch_rst === 1'b0 && rst_low == 0) rst_low = n;
            if (lut_start === 1'b1) lut_at = n;
        end while (vid_gate !== 1'b1 && n < 20);
        check("fetch_rst_low_at", rst_low, 5);
        check("lut_start_at", lut_at, 5);
        check("run_entry_at", n, 6);
    endtask

    task automatic send_beats(input int n, input int last_at, input int gap);
        for (int i = 1; i <= n; i++) begin
            repeat (gap) begin
                out_valid = 1'b1; out_ready = 1'b0; out_last = (i == last_at);
                step();
            end
            out_valid = 1'b1; out_ready = 1'b1; out_last = (i == last_at);
            step();
        end
        out_valid = 1'b0; out_ready = 1'b0; out_last = 1'b0;
    endtask

    task automatic compare_sb();
        exp_t e;
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_frame_cnt", frame_cnt, e.fc);
            check("sb_pix_cnt", pix_cnt, e.pix);
            check("sb_err_len", err_len, e.len);
            check("sb_err_ovr", err_ovr, e.ovr);
            check("sb_busy", busy, 0);
        end
    endtask

    task automatic finish_frame();
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("done_seen", frame_done, 1);
        step();
        check("done_single", frame_done, 0);
        compare_sb();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("rst_fetch_rst", fetch_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_outs", {lut_start, vid_gate, frame_done, err_len, err_ovr, err_tmo}, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_pix_cnt", pix_cnt, 0);
        rst = 1'b0;
        enable = 1'b1;
        step();
        check("idle_fetch_rst", fetch_rst, 1);

        // Frame 1: nominal 8 beats with a not-ready cycle ahead of each.
        sb.push_back('{fc: 16'd1, pix: 20'd8, len: 1'b0, ovr: 1'b0});
        start_frame();
        send_beats(8, 8, 1);
        check("f1_done_after_last", frame_done, 1);
        finish_frame();
        check("f1_err_tmo", err_tmo, 0);
`ifdef FETCH_CYCLE_STAT_EN
        check("f1_frame_cycles", frame_cycles, 17);
`endif

        // Frame 2: early last on beat 6.
        sb.push_back('{fc: 16'd2, pix: 20'd6, len: 1'b1, ovr: 1'b0});
        start_frame();
        send_beats(6, 6, 0);
        check("f2_done_after_last", frame_done, 1);
        finish_frame();

        // Frame 3: no last, overflow on beat 9.
        pulse_clr();
        check("f3_clr_len", err_len, 0);
        sb.push_back('{fc: 16'd3, pix: 20'd9, len: 1'b1, ovr: 1'b0});
        start_frame();
        send_beats(8, 0, 0);
        check("f3_len_b8", err_len, 0);
        check("f3_run_b8", vid_gate, 1);
        check("f3_pix_b8", pix_cnt, 8);
        send_beats(1, 0, 0);
        check("f3_len_b9", err_len, 1);
        check("f3_done_b9", frame_done, 1);
        finish_frame();

        // Frame 4: stall after 3 beats until the watchdog fires.
        pulse_clr();
        check("f4_clr_len", err_len, 0);
        start_frame();
        send_beats(3, 0, 0);
        repeat (15) step();
        check("f4_tmo_15", err_tmo, 0);
        check("f4_busy_15", busy, 1);
        step();
        check("f4_tmo_16", err_tmo, 1);
        check("f4_busy_16", busy, 0);
        check("f4_no_done", frame_done, 0);
        check("f4_frame_cnt", frame_cnt, 3);
        check("f4_pix_cnt", pix_cnt, 3);

        // Frame 5: overrun sync in RUN, clear racing the set, then a sync during DONE.
        pulse_clr();
        check("f5_clr_tmo", err_tmo, 0);
        sb.push_back('{fc: 16'd4, pix: 20'd8, len: 1'b0, ovr: 1'b0});
        start_frame();
        send_beats(2, 0, 0);
        Fsync = 1'b1;
        err_clr = 1'b1;
        step();
        Fsync = 1'b0;
        err_clr = 1'b0;
        check("f5_ovr_set", err_ovr, 1);
        check("f5_no_restart", vid_gate, 1);
        check("f5_pix_kept", pix_cnt, 2);
        pulse_clr();
        check("f5_ovr_clr", err_ovr, 0);
        send_beats(6, 6, 0);
        check("f5_done", frame_done, 1);
        Fsync = 1'b1;
        step();
        Fsync = 1'b0;
        check("f5_done_sync_ignored", busy, 0);
        check("f5_done_sync_no_ovr", err_ovr, 0);
        check("f5_done_single", frame_done, 0);
        compare_sb();
        enable = 1'b0;
        Fsync = 1'b1;
        step();
        Fsync = 1'b0;
        repeat (3) step();
        check("f5_disabled_busy", busy, 0);
        check("f5_disabled_fetch_rst", fetch_rst, 1);
        enable = 1'b1;

        // Frame 6: async reset mid-RUN, then a clean frame.
        start_frame();
        send_beats(3, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check("f6_async_fetch_rst", fetch_rst, 1);
        check("f6_async_busy", busy, 0);
        check("f6_async_gate", vid_gate, 0);
        check("f6_async_pix", pix_cnt, 0);
        check("f6_async_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        sb.push_back('{fc: 16'd1, pix: 20'd8, len: 1'b0, ovr: 1'b0});
        start_frame();
        check("f6_pix_start", pix_cnt, 0);
        send_beats(8, 8, 0);
        finish_frame();
        check("f6_flags", {err_len, err_ovr, err_tmo}, 0);

        check("lut_pulse_total", lut_pulses, 7);
        check("done_pulse_total", done_pulses, 5);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
